multicycle_controller: RTL

- Control FSM for the multicycle RV32I core.
- Sequences a shared instruction/data memory, one ALU, the PC, IR and register file across fetch/decode/execute/memory/writeback cycles.
- Takes the IR opcode plus datapath status (branch_taken, mem_ready) and drives every datapath mux select and write strobe.
- Sits between IR/datapath and the unified memory port, which it accesses via a req/ready handshake.

---
 rtl/multicycle_controller_pkg.sv | 59 +++++
 rtl/multicycle_controller_imm_src_decoder.sv | 21 ++
 rtl/multicycle_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared control encodings for the multicycle RV32I core: FSM states,
// opcodes and the datapath mux-select codes the controller drives.
package multicycle_controller_pkg;

  // Seventeen states need five bits of encoding.
  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_LUI,
    S_AUIPC,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEM       = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Opcode to immediate-format select; purely combinational so the
// single-cycle core can reuse it unchanged.
module imm_src_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:          imm_src = IMM_S;
      OP_BRANCH:         imm_src = IMM_B;
      OP_JAL:            imm_src = IMM_J;
      OP_LUI, OP_AUIPC:  imm_src = IMM_U;
      default:           imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences the shared memory,
// ALU, PC, IR and register file through fetch/decode/execute/mem/writeback.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       halted
);

  // XLEN only documents the datapath width; control is width-independent.
  if (XLEN < 32) begin : g_narrow_datapath
  end

  state_t state_q, state_d;
  logic   pc_update;
  logic   branch;

  imm_src_decoder u_imm_src_decoder (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      // Decode precomputes OldPC+imm so branch/JAL targets sit in ALUOut.
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      // PC takes the decode-time target while the ALU forms the link value.
      S_JAL: begin
        pc_update = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_d    = S_LINK;
      end
      S_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase

    pc_write = pc_update | (branch & branch_taken);
  end

endmodule
